// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage (ID->EX) with a 2-entry elastic buffer and synchronous flush.
// Optional feature: define IMM_EXT_BRANCH_EN to make mode 11 a branch offset (sign-extend, shift left 2).
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             head, head_nxt;
   logic             wr_en, wr_sel;
   logic             accept, pop;
   logic [OUT_W-1:0] ext_imm;
   logic [OUT_W-1:0] slot_imm [2];
   logic [TAG_W-1:0] slot_tag [2];

   generate
      if (IN_W == OUT_W) begin : g_pass
         assign ext_imm = in_imm;
      end else begin : g_ext
         logic [OUT_W-1:0] sext;
         assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
         always_comb begin
            ext_imm = sext;
            case (in_mode)
               2'b00:   ext_imm = sext;
               2'b01:   ext_imm = {{(OUT_W-IN_W){1'b0}}, in_imm};
               2'b10:   ext_imm = {in_imm, {(OUT_W-IN_W){1'b0}}};
               default: begin
`ifdef IMM_EXT_BRANCH_EN
                  ext_imm = sext << 2;
`else
                  ext_imm = sext;
`endif
               end
            endcase
         end
      end
   endgenerate

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign count     = state;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Head only advances when another entry remains, so an emptied stage keeps showing the last popped value.
   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      wr_en     = 1'b0;
      wr_sel    = head;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  wr_en     = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               wr_sel = ~head;
               if (accept && pop) begin
                  wr_en    = 1'b1;
                  head_nxt = ~head;
               end else if (accept) begin
                  wr_en     = 1'b1;
                  state_nxt = FULL;
               end else if (pop) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_nxt  = ~head;
                  state_nxt = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         head  <= 1'b0;
      end else begin
         state <= state_nxt;
         head  <= head_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            slot_imm[i] <= '0;
            slot_tag[i] <= '0;
         end
      end else if (wr_en) begin
         slot_imm[wr_sel] <= ext_imm;
         slot_tag[wr_sel] <= in_tag;
      end
   end

   assign out_imm = slot_imm[head];
   assign out_tag = slot_tag[head];
   assign out_neg = out_imm[OUT_W-1];

endmodule
